systolic_tile_sequencer: RTL and testbench

Parametrised, tiled successor to the fixed-size matrix-multiply controller. For an N×N problem with N a multiple of the array edge DIM, it generates skewed, per-lane read addresses into banked A/B memories, clears and drains a DIM×DIM systolic array tile by tile, and writes results row-major to O memory. It sits between the ap_start/ap_done host handshake and the array plus its memories, and replaces hard-coded sizes and base addresses with runtime configuration.

---
 rtl/systolic_pkg.sv | 37 +++
 rtl/systolic_lane_agen.sv | 63 ++++++
 rtl/systolic_tile_sequencer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_systolic_tile_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and helpers for the tiled systolic sequencer.
package systolic_pkg;

  // FSM encoding, kept as plain constants for tools that dislike enums.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CHECK = 3'd1;
  localparam state_t S_CLEAR = 3'd2;
  localparam state_t S_FEED  = 3'd3;
  localparam state_t S_FLUSH = 3'd4;
  localparam state_t S_DRAIN = 3'd5;
  localparam state_t S_NEXT  = 3'd6;
  localparam state_t S_DONE  = 3'd7;

  // Lane index within one operand edge of the array.
  typedef logic [7:0] lane_idx_t;

  // Flush and drain lengths for an array of edge dim.
  function automatic int flush_cyc(input int dim);
    return 2 * dim;
  endfunction

  function automatic int drain_cyc(input int dim);
    return dim * dim;
  endfunction

  // Lengths for the reference 4x4 array.
  localparam int DIM_DEFAULT = 4;
  localparam int FLUSH_CYC   = 2 * DIM_DEFAULT;
  localparam int DRAIN_CYC   = DIM_DEFAULT * DIM_DEFAULT;

  // Number of tiles along one matrix edge.
  function automatic int tiles(input int n, input int dim);
    return n / dim;
  endfunction

endpackage

// File: rtl/systolic_lane_agen.sv
// One operand lane: skew window, strided address accumulator, enable
// and the one-cycle valid delay that matches memory read latency.
module systolic_lane_agen #(
  parameter int LANE   = 0,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill_i,
  input  logic              load_i,
  input  logic              feed_i,
  input  logic [CNT_W-1:0]  f_i,
  input  logic [7:0]        n_i,
  input  logic [ADDR_W-1:0] init_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic              en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              vld_o
);

  logic [ADDR_W-1:0] acc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              en_q;
  logic              vld_q;
  logic [9:0]        f_ext;
  logic [9:0]        win_lo;
  logic [9:0]        win_hi;
  logic              active;

  // Lane r carries k = f - r while r <= f < r + N.
  assign f_ext  = 10'(f_i);
  assign win_lo = 10'(LANE);
  assign win_hi = win_lo + 10'(n_i);
  assign active = feed_i && (f_ext >= win_lo) && (f_ext < win_hi);

  // Accumulator holds the next address; the output only moves when issuing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      addr_q <= '0;
      en_q   <= 1'b0;
      vld_q  <= 1'b0;
    end else if (kill_i) begin
      en_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      en_q  <= active;
      vld_q <= en_q;
      if (load_i) begin
        acc_q <= init_i;
      end else if (active) begin
        addr_q <= acc_q;
        acc_q  <= acc_q + stride_i;
      end
    end
  end

  assign en_o   = en_q;
  assign addr_o = addr_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer for an N x N multiply on a DIM x DIM systolic array.
// Every output is a register loaded from the current state, so outputs
// trail the internal state by one cycle.
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int DIM    = 4,
  parameter int MAX_N  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ap_start,
  input  logic                    ap_abort,
  input  logic [7:0]              cfg_n,
  input  logic [ADDR_W-1:0]       cfg_a_base,
  input  logic [ADDR_W-1:0]       cfg_b_base,
  input  logic [ADDR_W-1:0]       cfg_o_base,
  output logic [DIM-1:0]          a_en,
  output logic [DIM-1:0]          b_en,
  output logic [DIM*ADDR_W-1:0]   a_addr,
  output logic [DIM*ADDR_W-1:0]   b_addr,
  output logic                    arr_clear,
  output logic [DIM-1:0]          arr_a_vld,
  output logic [DIM-1:0]          arr_b_vld,
  output logic [$clog2(DIM)-1:0]  drain_row,
  output logic [$clog2(DIM)-1:0]  drain_col,
  output logic                    o_we,
  output logic [ADDR_W-1:0]       o_addr,
  output logic                    busy,
  output logic                    ap_done,
  output logic                    err
);

  localparam int LD        = $clog2(DIM);
  localparam int FLUSH_LEN = (DIM == DIM_DEFAULT) ? FLUSH_CYC : flush_cyc(DIM);
  localparam int DRAIN_LEN = (DIM == DIM_DEFAULT) ? DRAIN_CYC : drain_cyc(DIM);
  localparam int CNT_W     = $clog2(MAX_N + DIM * DIM + 2 * DIM + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        ti_q, ti_d;
  logic [7:0]        tj_q, tj_d;
  logic              err_flag_q, err_flag_d;
  logic [ADDR_W-1:0] a_row_q, a_row_d;     // a_base + ti*DIM*N
  logic [ADDR_W-1:0] b_base_q, b_base_d;
  logic [ADDR_W-1:0] b_col_q, b_col_d;     // b_base + tj*DIM
  logic [ADDR_W-1:0] o_trow_q, o_trow_d;   // o_base + ti*DIM*N
  logic [ADDR_W-1:0] o_tile_q, o_tile_d;   // o_trow + tj*DIM
  logic [ADDR_W-1:0] o_row_q, o_row_d;     // o_tile + r*N during drain

  logic              busy_q, ap_done_q, err_q, arr_clear_q, o_we_q;
  logic [LD-1:0]     drain_row_q, drain_col_q;
  logic [ADDR_W-1:0] o_addr_q;

  logic [7:0]        t_last;
  logic [ADDR_W-1:0] tile_stride;
  logic              kill;
  logic              n_illegal;

  assign t_last      = 8'(tiles(int'(n_q), DIM) - 1);
  assign tile_stride = ADDR_W'(n_q) << LD;
  assign kill        = ap_abort && (state_q != S_IDLE);
  assign n_illegal   = (n_q == 8'd0) || (int'(n_q) > MAX_N) ||
                       ((n_q & 8'(DIM - 1)) != 8'd0);

  // Next-state and tile bookkeeping; abort overrides every transition.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    ti_d       = ti_q;
    tj_d       = tj_q;
    err_flag_d = err_flag_q;
    a_row_d    = a_row_q;
    b_base_d   = b_base_q;
    b_col_d    = b_col_q;
    o_trow_d   = o_trow_q;
    o_tile_d   = o_tile_q;
    o_row_d    = o_row_q;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d  = S_CHECK;
          n_d      = cfg_n;
          ti_d     = 8'd0;
          tj_d     = 8'd0;
          a_row_d  = cfg_a_base;
          b_base_d = cfg_b_base;
          b_col_d  = cfg_b_base;
          o_trow_d = cfg_o_base;
          o_tile_d = cfg_o_base;
        end
      end
      S_CHECK: begin
        err_flag_d = n_illegal;
        state_d    = n_illegal ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
        o_row_d = o_tile_q;
      end
      S_FEED: begin
        if (int'(cnt_q) == int'(n_q) + DIM - 2) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (int'(cnt_q) == FLUSH_LEN - 1) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q[LD-1:0] == LD'(DIM - 1)) begin
          o_row_d = o_row_q + ADDR_W'(n_q);
        end
        if (int'(cnt_q) == DRAIN_LEN - 1) begin
          state_d = S_NEXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (tj_q == t_last) begin
          tj_d    = 8'd0;
          b_col_d = b_base_q;
          if (ti_q == t_last) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_CLEAR;
            ti_d     = ti_q + 8'd1;
            a_row_d  = a_row_q + tile_stride;
            o_trow_d = o_trow_q + tile_stride;
            o_tile_d = o_trow_q + tile_stride;
          end
        end else begin
          state_d  = S_CLEAR;
          tj_d     = tj_q + 8'd1;
          b_col_d  = b_col_q + ADDR_W'(DIM);
          o_tile_d = o_tile_q + ADDR_W'(DIM);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (kill) begin
      state_d = S_IDLE;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      ti_q       <= '0;
      tj_q       <= '0;
      err_flag_q <= 1'b0;
      a_row_q    <= '0;
      b_base_q   <= '0;
      b_col_q    <= '0;
      o_trow_q   <= '0;
      o_tile_q   <= '0;
      o_row_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      ti_q       <= ti_d;
      tj_q       <= tj_d;
      err_flag_q <= err_flag_d;
      a_row_q    <= a_row_d;
      b_base_q   <= b_base_d;
      b_col_q    <= b_col_d;
      o_trow_q   <= o_trow_d;
      o_tile_q   <= o_tile_d;
      o_row_q    <= o_row_d;
    end
  end

  // Registered strobes decoded from the current state; abort zeroes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= 1'b0;
      ap_done_q   <= 1'b0;
      err_q       <= 1'b0;
      arr_clear_q <= 1'b0;
      o_we_q      <= 1'b0;
      drain_row_q <= '0;
      drain_col_q <= '0;
      o_addr_q    <= '0;
    end else if (kill) begin
      busy_q      <= 1'b0;
      ap_done_q   <= 1'b0;
      err_q       <= 1'b0;
      arr_clear_q <= 1'b0;
      o_we_q      <= 1'b0;
    end else begin
      busy_q      <= (state_q != S_IDLE) && (state_q != S_DONE);
      ap_done_q   <= (state_q == S_DONE);
      err_q       <= (state_q == S_DONE) && err_flag_q;
      arr_clear_q <= (state_q == S_CLEAR);
      o_we_q      <= (state_q == S_DRAIN);
      if (state_q == S_DRAIN) begin
        drain_row_q <= cnt_q[2*LD-1:LD];
        drain_col_q <= cnt_q[LD-1:0];
        o_addr_q    <= o_row_q + ADDR_W'(cnt_q[LD-1:0]);
      end
    end
  end

  // Row offsets r*N for the A lanes, built as an adder chain.
  logic [ADDR_W-1:0] a_off [DIM];
  assign a_off[0] = '0;
  for (genvar gi = 1; gi < DIM; gi++) begin : g_aoff
    assign a_off[gi] = a_off[gi-1] + ADDR_W'(n_q);
  end

  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    systolic_lane_agen #(.LANE(gi), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_a (
      .clk      (clk),
      .rst      (rst),
      .kill_i   (kill),
      .load_i   (state_q == S_CLEAR),
      .feed_i   (state_q == S_FEED),
      .f_i      (cnt_q),
      .n_i      (n_q),
      .init_i   (a_row_q + a_off[gi]),
      .stride_i (ADDR_W'(1)),
      .en_o     (a_en[gi]),
      .addr_o   (a_addr[gi*ADDR_W +: ADDR_W]),
      .vld_o    (arr_a_vld[gi])
    );
    systolic_lane_agen #(.LANE(gi), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_b (
      .clk      (clk),
      .rst      (rst),
      .kill_i   (kill),
      .load_i   (state_q == S_CLEAR),
      .feed_i   (state_q == S_FEED),
      .f_i      (cnt_q),
      .n_i      (n_q),
      .init_i   (b_col_q + ADDR_W'(gi)),
      .stride_i (ADDR_W'(n_q)),
      .en_o     (b_en[gi]),
      .addr_o   (b_addr[gi*ADDR_W +: ADDR_W]),
      .vld_o    (arr_b_vld[gi])
    );
  end

  assign busy      = busy_q;
  assign ap_done   = ap_done_q;
  assign err       = err_q;
  assign arr_clear = arr_clear_q;
  assign o_we      = o_we_q;
  assign o_addr    = o_addr_q;
  assign drain_row = drain_row_q;
  assign drain_col = drain_col_q;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: directed and random jobs against a
// cycle-indexed model built from the tile timing and address formulas.
module tb_systolic_tile_sequencer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_abort = 1'b0;
  logic [7:0]  cfg_n = 8'd0;
  logic [31:0] cfg_a_base = 32'd0;
  logic [31:0] cfg_b_base = 32'd0;
  logic [31:0] cfg_o_base = 32'd0;
  logic [D-1:0]    a_en, b_en, arr_a_vld, arr_b_vld;
  logic [D*32-1:0] a_addr, b_addr;
  logic        arr_clear, o_we, busy, ap_done, err;
  logic [1:0]  drain_row, drain_col;
  logic [31:0] o_addr;

  int passed = 0;
  int total  = 0;
  logic [31:0] o_log[$];

  systolic_tile_sequencer #(.DIM(D), .MAX_N(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .ap_abort(ap_abort),
    .cfg_n(cfg_n), .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base),
    .cfg_o_base(cfg_o_base), .a_en(a_en), .b_en(b_en), .a_addr(a_addr),
    .b_addr(b_addr), .arr_clear(arr_clear), .arr_a_vld(arr_a_vld),
    .arr_b_vld(arr_b_vld), .drain_row(drain_row), .drain_col(drain_col),
    .o_we(o_we), .o_addr(o_addr), .busy(busy), .ap_done(ap_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] all_outputs_or();
    return {32'd0, 8'd0, a_en, b_en, arr_a_vld, arr_b_vld, arr_clear, o_we, busy,
            ap_done, err, (|a_addr), (|b_addr), (|o_addr), (|{drain_row, drain_col})};
  endfunction

  task automatic run_job(input string name, input int n, input logic [31:0] ab,
                         input logic [31:0] bb, input logic [31:0] ob,
                         input int abort_k, input int rst_k, input int mid_k);
    bit illegal;
    int t, tc, kdone, kend, done_seen;
    bit aborted;
    logic [D-1:0] ea, eb, pa, pb;
    logic eclr, ewe, edone, eerr, ebusy;
    logic [31:0] eaddr_a [D];
    logic [31:0] eaddr_b [D];
    logic [31:0] eo;
    int er, ec;
    illegal = (n == 0) || (n > 16) || (n % D != 0);
    t       = illegal ? 0 : n / D;
    tc      = 1 + (n + D - 1) + 2 * D + D * D;
    kdone   = illegal ? 2 : 2 + t * t * (tc + 1);
    kend    = (abort_k >= 0) ? abort_k + 6 : ((rst_k >= 0) ? rst_k : kdone + 2);
    done_seen = -1;
    aborted = 0;
    pa = '0;
    pb = '0;
    o_log.delete();
    @(negedge clk);
    cfg_n = 8'(n); cfg_a_base = ab; cfg_b_base = bb; cfg_o_base = ob;
    ap_start = 1'b1;
    for (int k = 0; k <= kend; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 || k == mid_k + 1) ap_start = 1'b0;
      if (abort_k >= 0 && k == abort_k + 1) begin
        ap_abort = 1'b0;
        aborted  = 1;
      end
      ea = '0; eb = '0; eclr = 0; ewe = 0; er = 0; ec = 0; eo = 32'd0;
      for (int r = 0; r < D; r++) begin
        eaddr_a[r] = 32'd0;
        eaddr_b[r] = 32'd0;
      end
      ebusy = !aborted && (k >= 1) && (k < kdone);
      edone = !aborted && (k == kdone);
      eerr  = edone && illegal;
      if (!aborted && !illegal && k >= 2 && k < kdone) begin
        int m, p, ti, tj, f, d;
        m  = (k - 2) / (tc + 1);
        p  = (k - 2) % (tc + 1);
        ti = m / t;
        tj = m % t;
        eclr = (p == 0);
        if (p >= 1 && p <= n + D - 1) begin
          f = p - 1;
          for (int r = 0; r < D; r++) begin
            if (r <= f && f < r + n) begin
              ea[r] = 1'b1;
              eb[r] = 1'b1;
              eaddr_a[r] = ab + 32'((ti * D + r) * n + (f - r));
              eaddr_b[r] = bb + 32'((f - r) * n + tj * D + r);
            end
          end
        end
        d = p - n - 3 * D;
        if (d >= 0 && d < D * D) begin
          ewe = 1'b1;
          er  = d / D;
          ec  = d % D;
          eo  = ob + 32'((ti * D + er) * n + tj * D + ec);
        end
      end
      chk($sformatf("%s ctl k=%0d", name, k),
          64'({a_en, b_en, arr_a_vld, arr_b_vld, arr_clear, o_we, ap_done, err, busy}),
          64'({ea, eb, pa, pb, eclr, ewe, edone, eerr, ebusy}));
      for (int r = 0; r < D; r++) begin
        if (ea[r]) chk($sformatf("%s a_addr%0d k=%0d", name, r, k), 64'(a_addr[r*32 +: 32]), 64'(eaddr_a[r]));
        if (eb[r]) chk($sformatf("%s b_addr%0d k=%0d", name, r, k), 64'(b_addr[r*32 +: 32]), 64'(eaddr_b[r]));
      end
      if (ewe) begin
        chk($sformatf("%s drain k=%0d", name, k), 64'({drain_row, drain_col}), 64'({2'(er), 2'(ec)}));
        chk($sformatf("%s o_addr k=%0d", name, k), 64'(o_addr), 64'(eo));
      end
      if (o_we) o_log.push_back(o_addr);
      if (ap_done && done_seen < 0) done_seen = k;
      pa = ea;
      pb = eb;
      if (k == mid_k) begin
        ap_start = 1'b1;
        cfg_n = 8'd4; cfg_a_base = $urandom; cfg_b_base = $urandom; cfg_o_base = $urandom;
      end
      if (abort_k >= 0 && k == abort_k) ap_abort = 1'b1;
      if (k == rst_k) begin
        #2 rst = 1'b1;
        #1 chk($sformatf("%s async_rst", name), all_outputs_or(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
      end
    end
    if (abort_k < 0 && rst_k < 0)
      chk($sformatf("%s done_cycle", name), 64'(done_seen), 64'(kdone));
    else
      chk($sformatf("%s no_done", name), 64'(done_seen), 64'(-1));
    $display("job %s n=%0d a=%0h b=%0h o=%0h done_at=%0d writes=%0d",
             name, n, ab, bb, ob, done_seen, o_log.size());
  endtask

  initial begin
    int ns[4];
    int exp_t1[5];
    int n;
    ns = '{4, 8, 12, 16};
    exp_t1 = '{6148, 6149, 6150, 6151, 6156};
    repeat (3) @(posedge clk);
    #1 chk("reset_state", all_outputs_or(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_job("n4", 4, 32'd0, 32'd256, 32'd512, -1, -1, -1);
    chk("n4 writes", 64'(o_log.size()), 64'd16);
    for (int i = 0; i < 16 && i < o_log.size(); i++)
      chk($sformatf("n4 o_seq%0d", i), 64'(o_log[i]), 64'(512 + i));

    run_job("n8", 8, 32'd2048, 32'd4096, 32'd6144, -1, -1, 5);
    chk("n8 writes", 64'(o_log.size()), 64'd64);
    for (int i = 0; i < 5 && 16 + i < o_log.size(); i++)
      chk($sformatf("n8 tile1_w%0d", i), 64'(o_log[16 + i]), 64'(exp_t1[i]));

    run_job("bad6", 6, 32'd0, 32'd0, 32'd0, -1, -1, -1);
    run_job("bad20", 20, 32'd0, 32'd0, 32'd0, -1, -1, -1);
    run_job("bad0", 0, 32'd0, 32'd0, 32'd0, -1, -1, -1);

    run_job("abort", 8, 32'd100, 32'd200, 32'd300, 27, -1, -1);
    run_job("after_abort", 4, 32'd0, 32'd256, 32'd512, -1, -1, -1);

    run_job("rst_feed", 8, 32'd2048, 32'd4096, 32'd6144, -1, 6, -1);
    run_job("after_rst", 8, 32'd2048, 32'd4096, 32'd6144, -1, -1, -1);

    for (int j = 0; j < 6; j++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : ns[$urandom_range(0, 3)];
      run_job($sformatf("rnd%0d", j), n, $urandom, $urandom, $urandom, -1, -1,
              ((n % D == 0) && n > 0 && n <= 16) ? 7 : -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
